uart_word_rx: RTL
=================

// Module: uart_word_rx
// PURPOSE
// Serial front end of the boot path: oversampled UART receiver (8N1, LSB first) feeding the boot loader.
// Assembles received bytes into 16-bit words, high byte first, for 64x16 program RAM writes.
// Sits between pad rx and boot-loader RAM-write logic; all logic shares the clk/ce domain with CPU and RAM.
// PARAMETERS
// BAUD_DIV      54   ce-qualified clk cycles per oversample tick (bit time = 16*BAUD_DIV)
// TIMEOUT_BITS  32   idle bit-times after a high byte before that pending byte is discarded
// PORTS
// clk         in   1   system clock, rising edge
// rst         in   1   synchronous reset, active-low (0 = reset)
// ce          in   1   clock enable; when 0 all state, counters and outputs hold
// rx          in   1   asynchronous serial input, idle high
// byte_out    out  8   last correctly received byte
// byte_valid  out  1   one ce-cycle pulse: byte_out updated
// word_out    out  16  {high byte, low byte} of last completed pair
// word_valid  out  1   one ce-cycle pulse: word_out updated
// frame_err   out  1   one ce-cycle pulse: stop bit sampled 0
// busy        out  1   1 from start-bit detect until return to IDLE
// BEHAVIOUR
// - Reset (rst=0 at a clk edge, ce ignored): byte_out=0, word_out=0, all pulses 0, busy=0, state IDLE,
//   synchroniser flops=1, tick counter=0, pending-byte flag=0, timeout counter=0.
// - rx passes a 2-flop synchroniser (ce-gated); all decisions use the synchronised value.
// - Tick: counter BAUD_DIV-1..0, tick=1 for one ce-cycle at 0; runs only outside IDLE; reloads on IDLE->START.
// - FSM, tick index 0..15 per bit:
//   IDLE : synced rx=0 -> START, busy=1.
//   START: at tick 7 sample; 1 -> IDLE (glitch rejected, no pulse); 0 -> DATA, bit idx 0, realign so
//          following samples fall at 16-tick intervals (bit centres).
//   DATA : sample at each centre, shift in LSB first; after bit 7 -> STOP.
//   STOP : sample at centre; 1 -> byte_valid, byte_out<=data, IDLE; 0 -> frame_err, byte discarded, BREAK.
//   BREAK: wait for synced rx=1, then IDLE (no start detection while rx stays low).
// - Pulses registered, asserted on the ce-cycle following the deciding sample, cleared on next ce-cycle.
// - Word assembly: pending=0 -> byte held as high byte, pending=1; pending=1 -> word_out<={high,byte},
//   word_valid in same cycle as that byte_valid, pending=0.
// - frame_err clears pending (half word dropped; next good byte is a high byte).
// - Timeout: with pending=1 and FSM in IDLE, count ticks (free-running in IDLE while pending);
//   at TIMEOUT_BITS*16 ticks pending=0, no pulse. Counter clears on any start-bit detect.
// - Reset mid-frame aborts immediately; partial byte and pending byte lost.
// - Sampled rx glitches shorter than half a bit at bit centres are not filtered (single-sample decision).
// STRUCTURE
// - Shared include uart_defs.vh: FSM state encodings (IDLE, START, DATA, STOP, BREAK), OVERSAMPLE=16,
//   MID_TICK=7, frame constants (DATA_BITS=8).
// - One sub-module: uart_baud_tick (ce-gated BAUD_DIV divider with sync load; outputs tick).
// - Top: synchroniser, FSM + shift register, word assembler, timeout counter.
// TESTING (bench BAUD_DIV=4 -> 64 ce-cycles/bit unless noted)
// 1. Send 0xA5 then 0x3C back-to-back -> byte_valid x2 (0xA5, 0x3C); word_out=0xA53C with word_valid
//    coincident with second byte_valid; busy low between frames.
// 2. rx low for 2 ticks (8 cycles) then high -> no pulses, busy returns 0 by tick 8; next 0x11,0x22 -> 0x1122.
// 3. Send 0x55 with stop bit 0 -> frame_err pulse, no byte_valid; hold rx low 3 bit-times -> no false start;
//    then 0x12,0x34 -> word 0x1234.
// 4. Send 0x80 with stop bit 0 after good 0x77 -> frame_err, pending dropped; 0x01,0x02 -> word 0x0102.
// 5. Send 0x77 then idle 33 bit-times -> no word; then 0x01,0x02 -> word 0x0102 (not 0x7701).
// 6. rst=0 at middle of bit 4 of a frame -> next edge: all outputs 0, busy 0; following 0xDE,0xAD -> 0xDEAD.
// 7. ce random 50% duty, BAUD_DIV=2 -> scenario 1 results identical; pulses last exactly one ce-cycle.

Source files
------------

// File: rtl/uart_word_rx_pkg.sv
// Shared definitions for the UART word receiver: FSM state encoding and frame constants.
package uart_word_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_word_rx_baud_tick.sv
// ce-gated oversample divider: counts BAUD_DIV-1 down to 0 and flags a tick at 0.
module uart_word_rx_baud_tick #(
  parameter int BAUD_DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic i_run,
  input  logic i_load,
  output logic o_tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (ce) begin
      if (i_load) begin
        r_cnt <= RELOAD;
      end else if (i_run) begin
        r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
      end
    end
  end

  // A load restarts the phase, so it suppresses any tick in that cycle.
  assign o_tick = ce && i_run && !i_load && (r_cnt == '0);

endmodule

// File: rtl/uart_word_rx.sv
// Oversampled 8N1 receiver feeding the boot loader: bytes are paired into 16-bit words,
// high byte first. Every register advances only on ce.
module uart_word_rx
  import uart_word_rx_pkg::*;
#(
  parameter int BAUD_DIV     = 54,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        rx,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        frame_err,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_TICKS + 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_IDX   = 4'(MID_TICK);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rx_meta;
  logic            r_rx_sync;
  logic [3:0]      r_tick_idx;
  logic [3:0]      w_tick_idx_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_idx_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      r_high;
  logic            r_pending;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_tick;
  logic            w_run;
  logic            w_start_det;
  logic            w_shift_en;
  logic            w_byte_done;
  logic            w_frame_bad;
  logic            w_timeout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else if (ce) begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Ticks also run in IDLE while a high byte waits, to time its expiry.
  assign w_run = (r_state != ST_IDLE) || r_pending;

  uart_word_rx_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .i_run (w_run),
    .i_load(w_start_det),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_tick_idx <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else if (ce) begin
      r_state    <= w_state_nxt;
      r_tick_idx <= w_tick_idx_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      if (w_shift_en) r_shift <= {r_rx_sync, r_shift[7:1]};
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_idx_nxt = r_tick_idx;
    w_bit_idx_nxt  = r_bit_idx;
    w_start_det    = 1'b0;
    w_shift_en     = 1'b0;
    w_byte_done    = 1'b0;
    w_frame_bad    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!r_rx_sync) begin
          w_state_nxt    = ST_START;
          w_start_det    = 1'b1;
          w_tick_idx_nxt = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_tick_idx == MID_IDX) begin
            // Restarting the tick index here puts every later sample at a bit centre.
            w_tick_idx_nxt = '0;
            w_bit_idx_nxt  = '0;
            w_state_nxt    = r_rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            w_tick_idx_nxt = r_tick_idx + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_tick_idx == LAST_TICK) begin
            w_tick_idx_nxt = '0;
            w_shift_en     = 1'b1;
            if (r_bit_idx == LAST_BIT) w_state_nxt = ST_STOP;
            else                       w_bit_idx_nxt = r_bit_idx + 3'd1;
          end else begin
            w_tick_idx_nxt = r_tick_idx + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_tick_idx == LAST_TICK) begin
            w_tick_idx_nxt = '0;
            if (r_rx_sync) begin
              w_byte_done = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_frame_bad = 1'b1;
              w_state_nxt = ST_BREAK;
            end
          end else begin
            w_tick_idx_nxt = r_tick_idx + 4'd1;
          end
        end
      end
      ST_BREAK: begin
        if (r_rx_sync) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_timeout = r_pending && (r_state == ST_IDLE) && w_tick &&
                     (r_to_cnt == TO_W'(TO_TICKS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (ce) begin
      if (w_start_det || w_timeout) begin
        r_to_cnt <= '0;
      end else if (r_pending && (r_state == ST_IDLE) && w_tick) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  // Output handshake: valid-only pulses, no ready. byte_out/word_out are stable whenever
  // their valid is high and must be captured on that ce-cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_out   <= '0;
      byte_valid <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      r_high     <= '0;
      r_pending  <= 1'b0;
    end else if (ce) begin
      byte_valid <= w_byte_done;
      frame_err  <= w_frame_bad;
      word_valid <= 1'b0;
      if (w_byte_done) begin
        byte_out <= r_shift;
        if (r_pending) begin
          word_out   <= {r_high, r_shift};
          word_valid <= 1'b1;
          r_pending  <= 1'b0;
        end else begin
          r_high    <= r_shift;
          r_pending <= 1'b1;
        end
      end else if (w_frame_bad || w_timeout) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule
